conv_err_check: RTL and testbench

Convergence checker sitting directly downstream of the 4x4 element-wise absolute-error stage in the FastICA update loop. On a start pulse it snapshots the 16 absolute-error words (signed Q12.13, 26 bits) and a tolerance, scans them one per cycle to find the largest magnitude and its position, then reports whether the un-mixing matrix has converged (max error ≤ tolerance). The controller uses `done`/`converged` to decide between another iteration and exiting.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/err_max_cmp.sv | 41 ++++
 rtl/conv_err_check.sv | 256 +++++++++++++++++++++++++
 tb/tb_conv_err_check.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the FastICA convergence checker (conv_err_check).
//   DATA_W   : element width, signed two's complement Q12.13
//   FRAC_W   : fractional bits (informational, no scaling is done)
//   IDX_W    : width of a row-major 4x4 element index
//   NUM_ELEM : number of elements scanned per evaluation
//   ONE_Q13  : 1.0 in Q13
//   conv_state_e : IDLE / SCAN / FIN controller states
//   clamp_nonneg : maps negative (faulty) magnitudes to zero
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DATA_W   = 26;
    localparam int FRAC_W   = 13;
    localparam int IDX_W    = 4;
    localparam int NUM_ELEM = 16;

    localparam logic [DATA_W-1:0] ONE_Q13 = 26'd8192;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } conv_state_e;

    // Upstream delivers magnitudes only, so a negative word is an arithmetic
    // fault; treat it as zero error rather than letting it win or lose a compare.
    function automatic logic [DATA_W-1:0] clamp_nonneg(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v[DATA_W-1]) begin
            r = '0;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/err_max_cmp.sv
// ---------------------------------------------------------------------------
// err_max_cmp
// Combinational step of the running-maximum search: clamps the incoming
// element to >= 0 and replaces the running max only on a strictly greater
// value, so ties keep the earlier (lower) index.
// Ports:
//   elem     in  DATA_W  element under test (signed)
//   elem_idx in  IDX_W   row-major index of elem
//   cur_max  in  DATA_W  running maximum (always >= 0)
//   cur_idx  in  IDX_W   index of the running maximum
//   new_max  out DATA_W  updated maximum
//   new_idx  out IDX_W   updated index
// ---------------------------------------------------------------------------
module err_max_cmp
    import conv_pkg::*;
(
    input  logic [DATA_W-1:0] elem,
    input  logic [IDX_W-1:0]  elem_idx,
    input  logic [DATA_W-1:0] cur_max,
    input  logic [IDX_W-1:0]  cur_idx,
    output logic [DATA_W-1:0] new_max,
    output logic [IDX_W-1:0]  new_idx
);

    logic [DATA_W-1:0] clamped_s;

    // Clamp and strict-greater select of the new running maximum
    always_comb begin
        clamped_s = clamp_nonneg(elem);
        new_max   = cur_max;
        new_idx   = cur_idx;
        if ($signed(clamped_s) > $signed(cur_max)) begin
            new_max = clamped_s;
            new_idx = elem_idx;
        end else begin
            new_max = cur_max;
            new_idx = cur_idx;
        end
    end

endmodule

// File: rtl/conv_err_check.sv
// ---------------------------------------------------------------------------
// conv_err_check
// Convergence checker for the FastICA update loop. On start_conv (sampled in
// IDLE) it snapshots the 16 absolute-error words and the tolerance, scans one
// element per cycle for the largest clamped magnitude, then publishes
// max_err/max_idx and converged = (max <= tol), with a one-cycle done strobe.
// Start-to-done latency is 17 cycles.
//
// Optional feature macro: CONV_ITER_LIMIT_EN
//   defined   : iter_cnt counts consecutive non-converged evaluations,
//               saturating at MAX_ITER; iter_limit flags saturation.
//   undefined : iter_cnt/iter_limit are tied to 0 and clr_iter is ignored.
//
// Ports:
//   clk_conv    in   clock, rising edge
//   rstn_conv   in   asynchronous active-low reset
//   start_conv  in   evaluation request (IDLE only)
//   tol         in   DATA_W signed Q13 tolerance
//   i11..i44    in   DATA_W error elements, row-major (i11 = index 0)
//   clr_iter    in   synchronous clear of the iteration counter
//   busy        out  evaluation in progress
//   done        out  one-cycle result strobe
//   converged   out  last result, max_err <= tol
//   max_err     out  DATA_W largest clamped element
//   max_idx     out  IDX_W index of max_err
//   iter_cnt    out  ITER_W consecutive non-converged evaluations
//   iter_limit  out  iter_cnt == MAX_ITER
// ---------------------------------------------------------------------------
module conv_err_check
    import conv_pkg::*;
#(
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8
) (
    input  logic              clk_conv,
    input  logic              rstn_conv,
    input  logic              start_conv,
    input  logic [DATA_W-1:0] tol,
    input  logic [DATA_W-1:0] i11,
    input  logic [DATA_W-1:0] i12,
    input  logic [DATA_W-1:0] i13,
    input  logic [DATA_W-1:0] i14,
    input  logic [DATA_W-1:0] i21,
    input  logic [DATA_W-1:0] i22,
    input  logic [DATA_W-1:0] i23,
    input  logic [DATA_W-1:0] i24,
    input  logic [DATA_W-1:0] i31,
    input  logic [DATA_W-1:0] i32,
    input  logic [DATA_W-1:0] i33,
    input  logic [DATA_W-1:0] i34,
    input  logic [DATA_W-1:0] i41,
    input  logic [DATA_W-1:0] i42,
    input  logic [DATA_W-1:0] i43,
    input  logic [DATA_W-1:0] i44,
    input  logic              clr_iter,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [DATA_W-1:0] max_err,
    output logic [IDX_W-1:0]  max_idx,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              iter_limit
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    conv_state_e       state_r;
    conv_state_e       state_n;

    logic [DATA_W-1:0] snap_s [NUM_ELEM];
    logic [DATA_W-1:0] elem_r [NUM_ELEM];
    logic [DATA_W-1:0] tol_r;
    logic [DATA_W-1:0] run_max_r;
    logic [IDX_W-1:0]  run_idx_r;
    logic [IDX_W-1:0]  idx_r;
    logic [DATA_W-1:0] cmp_max_s;
    logic [IDX_W-1:0]  cmp_idx_s;
    logic              conv_s;

    logic              busy_r;
    logic              done_r;
    logic              conv_r;
    logic [DATA_W-1:0] max_err_r;
    logic [IDX_W-1:0]  max_idx_r;

    // Row-major view of the input matrix
    always_comb begin
        snap_s[0]  = i11;  snap_s[1]  = i12;  snap_s[2]  = i13;  snap_s[3]  = i14;
        snap_s[4]  = i21;  snap_s[5]  = i22;  snap_s[6]  = i23;  snap_s[7]  = i24;
        snap_s[8]  = i31;  snap_s[9]  = i32;  snap_s[10] = i33;  snap_s[11] = i34;
        snap_s[12] = i41;  snap_s[13] = i42;  snap_s[14] = i43;  snap_s[15] = i44;
    end

    err_max_cmp u_cmp (
        .elem     (elem_r[idx_r]),
        .elem_idx (idx_r),
        .cur_max  (run_max_r),
        .cur_idx  (run_idx_r),
        .new_max  (cmp_max_s),
        .new_idx  (cmp_idx_s)
    );

    // run_max_r is never negative, so a negative tolerance only passes when
    // it is not below the (zero) maximum, which the signed compare handles.
    assign conv_s = ($signed(run_max_r) <= $signed(tol_r));

    // FSM state register
    always_ff @(posedge clk_conv or negedge rstn_conv) begin
        if (!rstn_conv) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_conv) begin
                    state_n = ST_SCAN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == LAST_IDX) begin
                    state_n = ST_FIN;
                end else begin
                    state_n = ST_SCAN;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Snapshot and scan datapath
    always_ff @(posedge clk_conv or negedge rstn_conv) begin
        if (!rstn_conv) begin
            for (int k = 0; k < NUM_ELEM; k++) begin
                elem_r[k] <= '0;
            end
            tol_r     <= '0;
            run_max_r <= '0;
            run_idx_r <= '0;
            idx_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_conv) begin
                        for (int k = 0; k < NUM_ELEM; k++) begin
                            elem_r[k] <= snap_s[k];
                        end
                        tol_r     <= tol;
                        run_max_r <= '0;
                        run_idx_r <= '0;
                        idx_r     <= '0;
                    end
                end
                ST_SCAN: begin
                    run_max_r <= cmp_max_s;
                    run_idx_r <= cmp_idx_s;
                    idx_r     <= idx_r + 4'd1;
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    // Status and result registers
    always_ff @(posedge clk_conv or negedge rstn_conv) begin
        if (!rstn_conv) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            conv_r    <= 1'b0;
            max_err_r <= '0;
            max_idx_r <= '0;
        end else begin
            done_r <= (state_r == ST_FIN);
            case (state_r)
                ST_IDLE: begin
                    if (start_conv) begin
                        busy_r <= 1'b1;
                    end
                end
                ST_FIN: begin
                    busy_r    <= 1'b0;
                    conv_r    <= conv_s;
                    max_err_r <= run_max_r;
                    max_idx_r <= run_idx_r;
                end
                default: begin
                    busy_r <= busy_r;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign converged = conv_r;
    assign max_err   = max_err_r;
    assign max_idx   = max_idx_r;

`ifdef CONV_ITER_LIMIT_EN
    localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);

    logic [ITER_W-1:0] iter_r;
    logic [ITER_W-1:0] iter_n;
    logic              limit_r;

    // Iteration counter next value; an external clear beats the FIN update
    always_comb begin
        iter_n = iter_r;
        if (clr_iter) begin
            iter_n = '0;
        end else if (state_r == ST_FIN) begin
            if (conv_s) begin
                iter_n = '0;
            end else if (iter_r == MAX_ITER_V) begin
                iter_n = iter_r;
            end else begin
                iter_n = iter_r + 1'b1;
            end
        end else begin
            iter_n = iter_r;
        end
    end

    // Counter and limit flag; the flag compares the value being loaded so
    // both outputs change on the same edge
    always_ff @(posedge clk_conv or negedge rstn_conv) begin
        if (!rstn_conv) begin
            iter_r  <= '0;
            limit_r <= 1'b0;
        end else begin
            iter_r  <= iter_n;
            limit_r <= (iter_n == MAX_ITER_V);
        end
    end

    assign iter_cnt   = iter_r;
    assign iter_limit = limit_r;
`else
    logic unused_clr_iter;

    assign unused_clr_iter = clr_iter;
    assign iter_cnt        = '0;
    assign iter_limit      = 1'b0;
`endif

endmodule

// File: tb/tb_conv_err_check.sv
// ---------------------------------------------------------------------------
// tb_conv_err_check
// Self-checking bench for conv_err_check: directed cases plus randomized
// evaluations compared against a behavioural reference computed from the
// convergence rules. The DUT runs with MAX_ITER=3; when CONV_ITER_LIMIT_EN is
// defined the iteration counter is modelled, otherwise it must stay 0.
// ---------------------------------------------------------------------------
module tb_conv_err_check;

    localparam int MAXI = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        clr;
    logic [25:0] tol;
    logic [25:0] ein [16];
    logic        busy, done, converged, iter_limit;
    logic [25:0] max_err;
    logic [3:0]  max_idx;
    logic [7:0]  iter_cnt;

    int checks   = 0;
    int failures = 0;
    int ref_iter = 0;
    int mdl_e [16];
    int mdl_tol;

    always #5 clk = ~clk;

    conv_err_check #(.MAX_ITER(MAXI), .ITER_W(8)) dut (
        .clk_conv(clk), .rstn_conv(rstn), .start_conv(start), .tol(tol),
        .i11(ein[0]),  .i12(ein[1]),  .i13(ein[2]),  .i14(ein[3]),
        .i21(ein[4]),  .i22(ein[5]),  .i23(ein[6]),  .i24(ein[7]),
        .i31(ein[8]),  .i32(ein[9]),  .i33(ein[10]), .i34(ein[11]),
        .i41(ein[12]), .i42(ein[13]), .i43(ein[14]), .i44(ein[15]),
        .clr_iter(clr), .busy(busy), .done(done), .converged(converged),
        .max_err(max_err), .max_idx(max_idx), .iter_cnt(iter_cnt),
        .iter_limit(iter_limit)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: largest non-negative magnitude, first occurrence wins
    function automatic void ref_eval(output int mx, output int mi, output bit cv);
        mx = 0;
        mi = 0;
        for (int i = 0; i < 16; i++) begin
            int v;
            v = (mdl_e[i] < 0) ? 0 : mdl_e[i];
            if (v > mx) begin
                mx = v;
                mi = i;
            end
        end
        cv = (mx <= mdl_tol);
    endfunction

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_conv"}, 64'(converged), 64'd0);
        check_val({tag, "_max_err"}, 64'(max_err), 64'd0);
        check_val({tag, "_max_idx"}, 64'(max_idx), 64'd0);
        check_val({tag, "_iter_cnt"}, 64'(iter_cnt), 64'd0);
        check_val({tag, "_iter_limit"}, 64'(iter_limit), 64'd0);
    endtask

    // Drive one evaluation from mdl_e/mdl_tol and check its result
    task automatic run_eval(input bit extra_start, input bit clr_fin);
        int  cycles;
        bit  got;
        int  mx, mi, dn;
        bit  cv;
        @(negedge clk);
        for (int i = 0; i < 16; i++) ein[i] = 26'(mdl_e[i]);
        tol   = 26'(mdl_tol);
        start = 1'b1;
        @(posedge clk);
        #1 check_val("busy_after_start", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) ein[i] = 26'($urandom);
        tol    = 26'($urandom);
        cycles = 0;
        got    = 1'b0;
        while (cycles < 40 && !got) begin
            start = (extra_start && cycles == 4);
            clr   = (clr_fin && cycles == 16);
            @(posedge clk);
            cycles++;
            #1;
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        check_val("done_seen", 64'(got), 64'd1);
        check_val("latency", 64'(cycles), 64'd17);
        ref_eval(mx, mi, cv);
`ifdef CONV_ITER_LIMIT_EN
        if (clr_fin || cv) ref_iter = 0;
        else if (ref_iter < MAXI) ref_iter++;
        else ref_iter = MAXI;
`else
        ref_iter = 0;
`endif
        check_val("max_err", 64'(max_err), 64'(mx));
        check_val("max_idx", 64'(max_idx), 64'(mi));
        check_val("converged", 64'(converged), 64'(cv));
        check_val("busy_at_done", 64'(busy), 64'd0);
        check_val("iter_cnt", 64'(iter_cnt), 64'(ref_iter));
        check_val("iter_limit", 64'(iter_limit), 64'(ref_iter == MAXI));
        @(negedge clk);
        start = 1'b0;
        clr   = 1'b0;
        @(posedge clk);
        #1 check_val("done_one_cycle", 64'(done), 64'd0);
        if (extra_start) begin
            dn = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                #1 if (done) dn++;
            end
            check_val("no_queued_done", 64'(dn), 64'd0);
        end
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 16; i++) mdl_e[i] = v;
    endtask

    initial begin
        int dn;
        rstn  = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        tol   = 26'd0;
        for (int i = 0; i < 16; i++) ein[i] = 26'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        // All zero, tol 82
        fill(0); mdl_tol = 82;
        run_eval(1'b0, 1'b0);
        // Single peak at index 6
        fill(10); mdl_e[6] = 100; mdl_tol = 82;
        run_eval(1'b0, 1'b0);
        // Tie at indices 1 and 12, equality converges
        fill(0); mdl_e[1] = 500; mdl_e[12] = 500; mdl_tol = 500;
        run_eval(1'b0, 1'b0);
        // Negative element clamps to 0
        fill(5); mdl_e[15] = -8192; mdl_tol = 82;
        run_eval(1'b0, 1'b0);
        // Negative tolerance with all-zero matrix cannot converge
        fill(0); mdl_tol = -1;
        run_eval(1'b0, 1'b0);

        // Counter: four non-converged, one converged, clear in FIN
        fill(10); mdl_e[6] = 100; mdl_tol = 82;
        for (int r = 0; r < 4; r++) run_eval(1'b0, 1'b0);
        fill(0); mdl_tol = 82;
        run_eval(1'b0, 1'b0);
        fill(10); mdl_e[6] = 100; mdl_tol = 82;
        run_eval(1'b0, 1'b0);
        run_eval(1'b0, 1'b1);

        // Start re-pulsed mid-scan is ignored
        fill(7); mdl_e[9] = 300; mdl_tol = 299;
        run_eval(1'b1, 1'b0);

        // Randomized evaluations
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 9) == 0) mdl_e[i] = -int'($urandom_range(1, 100000));
                else mdl_e[i] = int'($urandom_range(0, 40)) * 10;
            end
            if ($urandom_range(0, 5) == 0) mdl_tol = -int'($urandom_range(1, 1000));
            else mdl_tol = int'($urandom_range(0, 450));
            run_eval(1'b0, ($urandom_range(0, 7) == 0));
        end

        // Reset at E9 aborts the evaluation with no done
        fill(10); mdl_e[3] = 1000; mdl_tol = 5;
        @(negedge clk);
        for (int i = 0; i < 16; i++) ein[i] = 26'(mdl_e[i]);
        tol   = 26'(mdl_tol);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        rstn = 1'b0;
        #1 check_all_zero("mid_scan_reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1 if (done) dn++;
        end
        check_val("aborted_no_done", 64'(dn), 64'd0);
        check_val("aborted_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
